// File: rtl/data_receiver_pkg.sv
// Shared types and constants for the data_receiver block: FSM states and
// the fixed RAM word addresses of the transfer layout.
package data_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_NT,
    GET_NX,
    GET_T,
    GET_X,
    DONE
  } state_t;

  localparam int BEAT_W                = 32;
  localparam int NUMBER_OF_T_ADDRESS   = 1;
  localparam int NUMBER_OF_X_ADDRESS   = 2;
  localparam int STARTING_OF_T_ADDRESS = 3;
  localparam int STARTING_OF_X_ADDRESS = 10;
  localparam int MAX_T                 = 7;

endpackage

// File: rtl/data_receiver_word_assembler.sv
// Packs 32-bit bus beats into RAM words: two beats (upper half first) for
// 64-bit words, one beat for 32-bit words.
module word_assembler
  import data_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clear,
  input  logic                  beat_valid,
  input  logic [BEAT_W-1:0]     beat,
  output logic                  word_done,
  output logic [DATA_WIDTH-1:0] word
);

  logic              half_q;
  logic [BEAT_W-1:0] upper_q;

  // clear drops a half-assembled word whenever the bus is not being accepted
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      half_q  <= 1'b0;
      upper_q <= '0;
    end else if (beat_valid) begin
      if (DATA_WIDTH == 64) half_q <= ~half_q;
      if (!half_q) upper_q <= beat;
    end
  end

  assign word_done = beat_valid && ((DATA_WIDTH == 32) || half_q);

  generate
    if (DATA_WIDTH == 64) begin : g_w64
      assign word = {upper_q, beat};
    end else begin : g_w32
      assign word = beat;
    end
  endgenerate

endmodule

// File: rtl/data_receiver.sv
// Receives a num_of_T / num_of_X / T / X word stream from the CPU bus and
// writes each word to RAM at its layout address, one registered strobe per word.
module data_receiver
  import data_receiver_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Receiving_Enable,
  input  logic [31:0]              CPU_Bus,
  input  logic                     Bus_Valid,
  output logic                     Bus_Ready,
  output logic                     RAM_Write_Enable,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic                     Done_Receiving,
  output logic                     Size_Error
);

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   num_t, num_x, t_cnt, x_cnt;
  logic [DATA_WIDTH-1:0]   nt_nxt, nx_nxt, t_nxt, x_nxt;
  logic [DATA_WIDTH-1:0]   t_full, x_full;
  logic [ADDRESS_WIDTH-1:0] addr_nxt;
  logic                    wr_nxt, size_set, t_last, in_get;
  logic                    word_done;
  logic [DATA_WIDTH-1:0]   word;

  assign in_get    = (state == GET_NT) || (state == GET_NX) ||
                     (state == GET_T)  || (state == GET_X);
  // Dropping Receiving_Enable closes the bus immediately so no beat lands mid-abort
  assign Bus_Ready = in_get && Receiving_Enable;

  word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (~Bus_Ready),
    .beat_valid(Bus_Valid && Bus_Ready),
    .beat      (CPU_Bus),
    .word_done (word_done),
    .word      (word)
  );

  // Full-width address arithmetic, truncated only when it reaches the port
  assign t_full = DATA_WIDTH'(STARTING_OF_T_ADDRESS) + t_cnt;
  assign x_full = DATA_WIDTH'(STARTING_OF_X_ADDRESS) + x_cnt + num_x * t_cnt;
  assign t_last = (t_cnt == num_t - DATA_WIDTH'(1));

  always_comb begin
    state_nxt = state;
    nt_nxt    = num_t;
    nx_nxt    = num_x;
    t_nxt     = t_cnt;
    x_nxt     = x_cnt;
    wr_nxt    = 1'b0;
    addr_nxt  = RAM_Address;
    size_set  = 1'b0;
    unique case (state)
      IDLE: if (Receiving_Enable) state_nxt = GET_NT;
      GET_NT: begin
        if (word_done) begin
          wr_nxt    = 1'b1;
          addr_nxt  = ADDRESS_WIDTH'(NUMBER_OF_T_ADDRESS);
          nt_nxt    = word;
          state_nxt = GET_NX;
        end else if (!Receiving_Enable) state_nxt = IDLE;
      end
      GET_NX: begin
        if (word_done) begin
          wr_nxt   = 1'b1;
          addr_nxt = ADDRESS_WIDTH'(NUMBER_OF_X_ADDRESS);
          nx_nxt   = word;
          t_nxt    = '0;
          x_nxt    = '0;
          if (num_t > DATA_WIDTH'(MAX_T)) begin
            size_set  = 1'b1;
            state_nxt = DONE;
          end else if (num_t == '0) state_nxt = DONE;
          else                      state_nxt = GET_T;
        end else if (!Receiving_Enable) state_nxt = IDLE;
      end
      GET_T: begin
        if (word_done) begin
          wr_nxt   = 1'b1;
          addr_nxt = ADDRESS_WIDTH'(t_full);
          if (num_x == '0) begin
            if (t_last) state_nxt = DONE;
            else        t_nxt     = t_cnt + DATA_WIDTH'(1);
          end else begin
            x_nxt     = '0;
            state_nxt = GET_X;
          end
        end else if (!Receiving_Enable) state_nxt = IDLE;
      end
      GET_X: begin
        if (word_done) begin
          wr_nxt   = 1'b1;
          addr_nxt = ADDRESS_WIDTH'(x_full);
          if (x_cnt == num_x - DATA_WIDTH'(1)) begin
            x_nxt = '0;
            if (t_last) state_nxt = DONE;
            else begin
              t_nxt     = t_cnt + DATA_WIDTH'(1);
              state_nxt = GET_T;
            end
          end else x_nxt = x_cnt + DATA_WIDTH'(1);
        end else if (!Receiving_Enable) state_nxt = IDLE;
      end
      DONE: if (!Receiving_Enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      num_t            <= '0;
      num_x            <= '0;
      t_cnt            <= '0;
      x_cnt            <= '0;
      RAM_Write_Enable <= 1'b0;
      RAM_Address      <= '0;
      RAM_Data         <= '0;
      Done_Receiving   <= 1'b0;
      Size_Error       <= 1'b0;
    end else begin
      state            <= state_nxt;
      num_t            <= nt_nxt;
      num_x            <= nx_nxt;
      t_cnt            <= t_nxt;
      x_cnt            <= x_nxt;
      RAM_Write_Enable <= wr_nxt;
      if (wr_nxt) begin
        RAM_Address <= addr_nxt;
        RAM_Data    <= word;
      end
      // Entering DONE coincides with the last write pulse, so done lags it by one cycle
      Done_Receiving <= (state == DONE) && Receiving_Enable;
      if (state_nxt == IDLE) Size_Error <= 1'b0;
      else if (size_set)     Size_Error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_receiver.sv
// Scoreboard bench for data_receiver: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every write strobe.
module tb_data_receiver;

  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        CLK = 0;
  logic        RST = 1;
  logic        Receiving_Enable = 0;
  logic [31:0] CPU_Bus = '0;
  logic        Bus_Valid = 0;
  logic        Bus_Ready, RAM_Write_Enable, Done_Receiving, Size_Error;
  logic [12:0] RAM_Address;
  logic [63:0] RAM_Data;

  int          n_vec  = 0;
  int          n_fail = 0;
  wr_t         sb[$];
  logic [12:0] alog[$];

  data_receiver #(.ADDRESS_WIDTH(13), .DATA_WIDTH(64)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .Receiving_Enable(Receiving_Enable),
    .CPU_Bus         (CPU_Bus),
    .Bus_Valid       (Bus_Valid),
    .Bus_Ready       (Bus_Ready),
    .RAM_Write_Enable(RAM_Write_Enable),
    .RAM_Address     (RAM_Address),
    .RAM_Data        (RAM_Data),
    .Done_Receiving  (Done_Receiving),
    .Size_Error      (Size_Error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RAM_Write_Enable) begin
      alog.push_back(RAM_Address);
      if (sb.size() == 0) chk("unexpected_write_addr", 64'(RAM_Address), 64'hFFFF);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(RAM_Address), 64'(e.addr));
        chk("wr_data", RAM_Data, e.data);
      end
    end
  end

  function automatic logic [63:0] tval(input int t);
    if (t == 0) return 64'h1234_5678_9ABC_DEF0;
    return {32'hA000_0000 + 32'(t), 32'h5000_0000 + 32'(t)};
  endfunction

  function automatic logic [63:0] xval(input int t, input int x);
    return {32'hC000_0000 + 32'(t * 16 + x), 32'h3000_0000 + 32'(t * 16 + x)};
  endfunction

  // Called at #1 after an edge; returns at #1 after the edge that took the beat.
  task automatic send_beat(input logic [31:0] b, input int gap);
    bit got = 0;
    if (gap > 0) begin
      Bus_Valid = 0;
      repeat (gap) begin @(posedge CLK); #1; end
    end
    Bus_Valid = 1;
    CPU_Bus   = b;
    for (int i = 0; i < 50 && !got; i++) begin
      if (Bus_Ready) got = 1;
      @(posedge CLK); #1;
    end
    if (!got) chk("beat_accept_timeout", 64'd0, 64'd1);
    Bus_Valid = 0;
  endtask

  // stop_mode: 0 drop Receiving_Enable, 1 assert RST, at beat number stop_beat
  task automatic xfer(input int nt, input int nx, input bit rnd,
                      input int stop_beat, input int stop_mode);
    wr_t words[$];
    int  nb = 0;
    bit  first_x = 1;
    words.push_back('{13'd1, 64'(nt)});
    words.push_back('{13'd2, 64'(nx)});
    if (nt <= 7)
      for (int t = 0; t < nt; t++) begin
        words.push_back('{13'(3 + t), tval(t)});
        for (int x = 0; x < nx; x++) words.push_back('{13'(10 + x + nx * t), xval(t, x)});
      end
    Receiving_Enable = 1;
    foreach (words[i]) begin
      int g1, g2;
      g1 = rnd ? $urandom_range(0, 2) : 0;
      g2 = rnd ? $urandom_range(0, 2) : 0;
      if (rnd && first_x && words[i].addr >= 13'd10) begin g2 = 2; first_x = 0; end
      send_beat(words[i].data[63:32], g1);
      nb++;
      if (nb == stop_beat) begin
        if (stop_mode == 1) RST = 1;
        Receiving_Enable = 0;
        return;
      end
      sb.push_back(words[i]);
      send_beat(words[i].data[31:0], g2);
      nb++;
    end
    chk("done_during_last_write", 64'(Done_Receiving), 64'd0);
    chk("last_write_strobe", 64'(RAM_Write_Enable), 64'd1);
    @(posedge CLK); #1;
    chk("done_after_last_write", 64'(Done_Receiving), 64'd1);
    chk("size_error", 64'(Size_Error), 64'(nt > 7));
    chk("ready_in_done", 64'(Bus_Ready), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    Receiving_Enable = 0;
    @(posedge CLK); #1;
    chk("done_clear", 64'(Done_Receiving), 64'd0);
    chk("size_error_clear", 64'(Size_Error), 64'd0);
    @(posedge CLK); #1;
  endtask

  task automatic chk_alog(input string nm);
    logic [12:0] exp_a[10];
    exp_a = '{13'd1, 13'd2, 13'd3, 13'd10, 13'd11, 13'd12, 13'd4, 13'd13, 13'd14, 13'd15};
    chk({nm, "_count"}, 64'(alog.size()), 64'd10);
    for (int i = 0; i < 10 && i < alog.size(); i++) chk(nm, 64'(alog[i]), 64'(exp_a[i]));
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", 64'(Bus_Ready), 0);
    chk("rst_we", 64'(RAM_Write_Enable), 0);
    chk("rst_addr", 64'(RAM_Address), 0);
    chk("rst_data", RAM_Data, 0);
    chk("rst_done", 64'(Done_Receiving), 0);
    chk("rst_size", 64'(Size_Error), 0);
    RST = 0;
    @(posedge CLK); #1;

    alog.delete();
    xfer(2, 3, 0, -1, 0);
    chk_alog("seq_b2b");

    alog.delete();
    xfer(2, 3, 1, -1, 0);
    chk_alog("seq_gaps");

    alog.delete();
    xfer(0, 3, 0, -1, 0);
    chk("nt0_writes", 64'(alog.size()), 64'd2);

    alog.delete();
    xfer(8, 3, 0, -1, 0);
    chk("nt8_writes", 64'(alog.size()), 64'd2);

    xfer(3, 0, 1, -1, 0);
    xfer(7, 2, 1, -1, 0);

    // Abort after the upper half of X[0][1] (beat 9)
    xfer(2, 3, 0, 9, 0);
    @(posedge CLK); #1;
    chk("abort_ready", 64'(Bus_Ready), 0);
    chk("abort_done", 64'(Done_Receiving), 0);
    repeat (3) begin @(posedge CLK); #1; end
    chk("abort_no_write", 64'(sb.size()), 0);
    alog.delete();
    xfer(2, 3, 0, -1, 0);
    chk_alog("after_abort");

    // Reset in the middle of the upper half of T[1] (beat 13)
    xfer(2, 3, 1, 13, 1);
    @(posedge CLK); #1;
    chk("mid_rst_ready", 64'(Bus_Ready), 0);
    chk("mid_rst_we", 64'(RAM_Write_Enable), 0);
    chk("mid_rst_addr", 64'(RAM_Address), 0);
    chk("mid_rst_data", RAM_Data, 0);
    chk("mid_rst_done", 64'(Done_Receiving), 0);
    chk("mid_rst_size", 64'(Size_Error), 0);
    chk("mid_rst_sb", 64'(sb.size()), 0);
    RST = 0;
    @(posedge CLK); #1;
    alog.delete();
    xfer(2, 3, 0, -1, 0);
    chk_alog("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_receiver.md
DATA_RECEIVER -- requirements
Module: data_receiver

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 13, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, RAM word width; legal values are 32 and 64.
REQ-003 SHALL have port CLK, input, 1, single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port Receiving_Enable, input, 1, high for the whole transfer; low aborts it.
REQ-006 SHALL have port CPU_Bus, input, 32, beat data from the CPU.
REQ-007 SHALL have port Bus_Valid, input, 1, CPU_Bus holds a valid beat this cycle.
REQ-008 SHALL have port Bus_Ready, output, 1, block accepts a beat this cycle.
REQ-009 SHALL have port RAM_Write_Enable, output, 1, single-cycle RAM write strobe.
REQ-010 SHALL have port RAM_Address, output, ADDRESS_WIDTH, write address.
REQ-011 SHALL have port RAM_Data, output, DATA_WIDTH, write data.
REQ-012 SHALL have port Done_Receiving, output, 1, transfer complete.
REQ-013 SHALL have port Size_Error, output, 1, header rejected.

Function
REQ-014 A beat SHALL be accepted on a rising edge where Bus_Valid and Bus_Ready are both 1; other beats are ignored.
REQ-015 With DATA_WIDTH 64, each word SHALL be two beats, upper half [63:32] first, then lower half [31:0]; with DATA_WIDTH 32, each word SHALL be one beat.
REQ-016 The stream order SHALL be: num_of_T, num_of_X, then for t = 0..num_of_T-1 one T word followed by num_of_X X words.
REQ-017 Word addresses SHALL be: num_of_T -> 1; num_of_X -> 2; T[t] -> 3+t; X[t][x] -> 10 + x + num_of_X*t, truncated to ADDRESS_WIDTH.
REQ-018 The FSM SHALL have states IDLE, GET_NT, GET_NX, GET_T, GET_X, DONE.
REQ-019 IDLE SHALL go to GET_NT when Receiving_Enable is 1.
REQ-020 Each GET state SHALL advance when a word completes: GET_NT -> GET_NX; GET_NX -> GET_T, or DONE if num_of_T = 0 or there is a size error; GET_T -> GET_X, or -> GET_T/DONE if num_of_X = 0; GET_X -> GET_T or DONE after the last X of the last T.
REQ-021 Bus_Ready SHALL be 1 only in the GET_* states.
REQ-022 RAM_Write_Enable SHALL pulse high for exactly one cycle, registered, in the cycle after the edge accepting the word's final beat; RAM_Address and RAM_Data SHALL be valid in that same cycle.
REQ-023 Back-to-back words SHALL be supported with no bubble: one write per word, throughput limited only by Bus_Valid.
REQ-024 Size_Error SHALL be set when num_of_T > 7; the two header words SHALL still be written; no data words SHALL be written; the FSM SHALL then go to DONE.
REQ-025 Done_Receiving SHALL rise in the cycle after the final write pulse, or after the header write when num_of_T = 0 or Size_Error is set.
REQ-026 Done_Receiving and Size_Error SHALL hold until Receiving_Enable falls; the FSM SHALL then return to IDLE, and both flags SHALL clear.
REQ-027 If Receiving_Enable falls in any GET state, the FSM SHALL return to IDLE on the next edge, discard any half-assembled word, and issue no write.
REQ-028 The T and X counters SHALL be at least DATA_WIDTH wide; the num_of_X*t product SHALL be computed at full width before truncation.

Reset
REQ-029 On RST: state IDLE; Bus_Ready, RAM_Write_Enable, Done_Receiving and Size_Error = 0; RAM_Address, RAM_Data and all counters = 0; the half-word flag is cleared.
REQ-030 RST SHALL take priority over every other input, including a mid-word beat.

Structure
REQ-031 The shared package SHALL hold the FSM state typedef and the address constants NUMBER_OF_T_ADDRESS = 1, NUMBER_OF_X_ADDRESS = 2, STARTING_OF_T_ADDRESS = 3, STARTING_OF_X_ADDRESS = 10, and MAX_T = 7.
REQ-032 The block SHALL contain one sub-module, word_assembler: it takes beats in and produces a word-complete pulse and the assembled word.

Verification
REQ-033 Stream NT=2, NX=3, with Bus_Valid held high -> 2+2+6 = 10 writes, to addresses 1, 2, 3, 10, 11, 12, 4, 13, 14, 15; Done_Receiving is 1 one cycle after the tenth write.
REQ-034 Beat pair 0x12345678, 0x9ABCDEF0 as the first T word -> RAM_Data = 0x123456789ABCDEF0 at address 3.
REQ-035 Random Bus_Valid gaps, including a gap between the two halves of a word -> same write sequence and data as REQ-033.
REQ-036 NT=0 -> only addresses 1 and 2 written, Done_Receiving is 1; NT=8 -> Size_Error = 1, Done_Receiving = 1, no write at address 3 or above.
REQ-037 Receiving_Enable dropped after the upper half of X[0][1] -> no further writes, state IDLE; a new transfer afterwards completes correctly.
REQ-038 RST asserted mid-stream -> every output is 0 on the next edge, and a subsequent full transfer passes.
